wb_stream_arbiter: RTL
======================

// Module: wb_stream_arbiter
// PURPOSE
//  Round-robin arbiter sharing one Wishbone master port (memory bus) between NUM_MASTERS
//  burst-capable DMA engines (stream writers/readers). Grant is held for a whole bus cycle
//  (cyc high), so incrementing bursts are never split.
//  Sits between the engines' wbm_* ports and the system interconnect.
// PARAMETERS
//  WB_AW        32  Wishbone address width
//  WB_DW        32  Wishbone data width; sel width = WB_DW/8
//  NUM_MASTERS  2   requesters, >=2; index width MW = $clog2(NUM_MASTERS)
//  TIMEOUT      255 watchdog limit in cycles (used only with WB_ARB_TIMEOUT_EN), >=1
// PORTS
//  wb_clk_i     in   1               clock, all logic on rising edge
//  wb_rst_n_i   in   1               asynchronous active-low reset
//  wbm_adr_i    in   NUM_MASTERS*WB_AW     requester addresses, master i at [i*WB_AW +: WB_AW]
//  wbm_dat_i    in   NUM_MASTERS*WB_DW     requester write data, same packing
//  wbm_sel_i    in   NUM_MASTERS*WB_DW/8   requester byte selects
//  wbm_we_i     in   NUM_MASTERS           requester write enables
//  wbm_cyc_i    in   NUM_MASTERS           requester cycle (= bus request)
//  wbm_stb_i    in   NUM_MASTERS           requester strobes
//  wbm_cti_i    in   NUM_MASTERS*3         requester cycle type
//  wbm_bte_i    in   NUM_MASTERS*2         requester burst type
//  wbm_dat_o    out  WB_DW           read data, broadcast to all requesters
//  wbm_ack_o    out  NUM_MASTERS     ack, only granted bit may be high
//  wbm_err_o    out  NUM_MASTERS     err, only granted bit may be high
//  wbm_rty_o    out  NUM_MASTERS     rty, only granted bit may be high
//  wbs_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o  out  shared bus request, std widths
//  wbs_dat_i/ack_i/err_i/rty_i       in   shared bus response
//  grant_o      out  MW              index of current/last owner
//  busy_o       out  1               bus owned (state != IDLE)
// BEHAVIOUR
//  States: IDLE, OWN, ABORT (ABORT only with WB_ARB_TIMEOUT_EN).
//  Reset: state=IDLE, grant_o=0, rr pointer=0. All wbs_* outputs 0, ack/err/rty 0, busy_o 0.
//  IDLE: if any wbm_cyc_i, pick first requester at or after pointer (cyclic) -> grant_o,
//   OWN next cycle. Arbitration latency exactly 1 cycle: cyc seen at edge N, wbs_cyc_o high
//   from N+1. No request -> stay IDLE.
//  OWN: wbs_* = granted requester's signals combinationally. wbs_cyc_o = its wbm_cyc_i.
//   Its ack/err/rty bits = wbs_*_i; other bits forced 0. Other requesters' inputs ignored.
//  Release: granted wbm_cyc_i low in OWN -> wbs_cyc_o/stb_o low same cycle, IDLE next cycle,
//   pointer = (grant+1) mod NUM_MASTERS. A new grant needs one IDLE cycle: bus gap >=1 cycle.
//  Burst/cti changes never release; only cyc deassertion does.
//  IDLE: wbs_cyc_o/stb_o/we_o = 0; adr/dat/sel/cti/bte = 0.
//  Simultaneous requests: strict round-robin.
//   Owner re-requesting after release loses to any other pending requester.
//  Mid-operation reset: immediate return to reset values; no ack is forwarded.
//  wbs_err_i/rty_i are forwarded only; the arbiter never retries.
// CONFIGURATION
//  `WB_ARB_TIMEOUT_EN defined: WB_AW-independent counter (width $clog2(TIMEOUT+1)).
//   Cleared on entry to OWN and on every ack/err/rty. Counts cycles with wbs_stb_o high.
//   Reaching TIMEOUT -> ABORT.
//   ABORT: wbs_cyc_o/stb_o 0. Granted wbm_err_o pulsed high for exactly 1 cycle.
//   Then wait for granted wbm_cyc_i low -> IDLE, pointer advances.
//  Not defined: no counter, no ABORT state. A stalled slave holds the bus indefinitely.
// TESTING
//  1 reset: assert wb_rst_n_i=0 mid-burst -> all outputs 0, grant_o=0 asynchronously.
//  2 single: M0 4-beat burst (cti 010,010,010,111), slave acks each cycle.
//    -> wbs_cyc_o high 1 cycle after request, 4 acks on wbm_ack_o[0] only.
//  3 contention: M0,M1 request in same cycle from reset -> M0 granted.
//    M1 granted 2 cycles after M0 drops cyc. Third round with both -> M0 again.
//  4 no split: M1 requests during M0 8-beat burst with slave wait states.
//    -> wbs_adr_o stays M0's for all 8 beats; M1 never sees ack.
//  5 NUM_MASTERS=3, all request continuously with 1-beat cycles -> grant order 0,1,2,0,1,2.
//  6 WB_ARB_TIMEOUT_EN, TIMEOUT=16, slave never acks
//    -> wbm_err_o[grant] 1-cycle pulse after 16 stb cycles, wbs_cyc_o low.
//    Next requester granted after owner drops cyc.

Source files
------------

// File: rtl/wb_stream_arbiter.sv
// ---------------------------------------------------------------------------
// wb_stream_arbiter
//
// Round-robin arbiter that shares one Wishbone master port between
// NUM_MASTERS burst-capable DMA engines. Ownership is held for a whole bus
// cycle (owner's cyc high), so incrementing bursts are never split. A new
// grant is always preceded by at least one idle cycle on the shared bus.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to enable a stall watchdog.
// It counts strobe cycles without a slave response; reaching TIMEOUT aborts
// the cycle (one-cycle err pulse to the owner, then wait for the owner to
// drop cyc).
//
// Parameters
//   WB_AW        address width
//   WB_DW        data width (sel width = WB_DW/8)
//   NUM_MASTERS  number of requesters (>= 2)
//   TIMEOUT      watchdog limit in strobe cycles (>= 1, watchdog builds only)
//
// Ports
//   wb_clk_i, wb_rst_n_i    clock / asynchronous active-low reset
//   wbm_*_i                 packed requester buses, master i at slice i
//   wbm_dat_o               read data broadcast to all requesters
//   wbm_ack_o/err_o/rty_o   per-requester responses, only owner bit can be 1
//   wbs_*_o                 shared request toward the interconnect
//   wbs_dat_i/ack_i/err_i/rty_i  shared response from the interconnect
//   grant_o                 index of current / last owner
//   busy_o                  bus owned (state != IDLE)
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | no owner; round-robin pick among asserted wbm_cyc_i
// OWN   | grant_o owns the bus; its signals are muxed to wbs_*
// ABORT | watchdog fired; err pulsed once, waiting for owner to drop cyc
// ---------------------------------------------------------------------------
module wb_stream_arbiter #(
    parameter int WB_AW       = 32,
    parameter int WB_DW       = 32,
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_n_i,

    input  logic [NUM_MASTERS*WB_AW-1:0]      wbm_adr_i,
    input  logic [NUM_MASTERS*WB_DW-1:0]      wbm_dat_i,
    input  logic [NUM_MASTERS*WB_DW/8-1:0]    wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]            wbm_we_i,
    input  logic [NUM_MASTERS-1:0]            wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]            wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]          wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]          wbm_bte_i,
    output logic [WB_DW-1:0]                  wbm_dat_o,
    output logic [NUM_MASTERS-1:0]            wbm_ack_o,
    output logic [NUM_MASTERS-1:0]            wbm_err_o,
    output logic [NUM_MASTERS-1:0]            wbm_rty_o,

    output logic [WB_AW-1:0]                  wbs_adr_o,
    output logic [WB_DW-1:0]                  wbs_dat_o,
    output logic [WB_DW/8-1:0]                wbs_sel_o,
    output logic                              wbs_we_o,
    output logic                              wbs_cyc_o,
    output logic                              wbs_stb_o,
    output logic [2:0]                        wbs_cti_o,
    output logic [1:0]                        wbs_bte_o,
    input  logic [WB_DW-1:0]                  wbs_dat_i,
    input  logic                              wbs_ack_i,
    input  logic                              wbs_err_i,
    input  logic                              wbs_rty_i,

    output logic [$clog2(NUM_MASTERS)-1:0]    grant_o,
    output logic                              busy_o
);

    localparam int MW = $clog2(NUM_MASTERS);
    localparam int SW = WB_DW / 8;

    if (NUM_MASTERS < 2) begin : g_chk_masters
        $error("wb_stream_arbiter: NUM_MASTERS must be >= 2");
    end
    if (TIMEOUT < 1) begin : g_chk_timeout
        $error("wb_stream_arbiter: TIMEOUT must be >= 1");
    end

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_ABORT = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1
    } state_e;
`endif

    state_e          state_q, state_d;
    logic [MW-1:0]   grant_q, grant_d;
    logic [MW-1:0]   ptr_q,   ptr_d;

    logic [MW-1:0]   rr_pick;
    logic [MW-1:0]   rr_idx;
    logic [MW:0]     rr_sum;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            err_pulse_q, err_pulse_d;
`endif

    // Unpacked views of the multi-bit requester fields.
    logic [WB_AW-1:0] m_adr [NUM_MASTERS];
    logic [WB_DW-1:0] m_dat [NUM_MASTERS];
    logic [SW-1:0]    m_sel [NUM_MASTERS];
    logic [2:0]       m_cti [NUM_MASTERS];
    logic [1:0]       m_bte [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign m_adr[i] = wbm_adr_i[i*WB_AW +: WB_AW];
        assign m_dat[i] = wbm_dat_i[i*WB_DW +: WB_DW];
        assign m_sel[i] = wbm_sel_i[i*SW +: SW];
        assign m_cti[i] = wbm_cti_i[i*3 +: 3];
        assign m_bte[i] = wbm_bte_i[i*2 +: 2];
    end

    function automatic logic [MW-1:0] next_idx(input logic [MW-1:0] g);
        if (g == MW'(NUM_MASTERS - 1)) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    // First requester at or after ptr_q, cyclically. Scanning offsets from
    // the far end down lets the smallest offset win.
    always_comb begin
        rr_pick = ptr_q;
        rr_sum  = '0;
        rr_idx  = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            rr_sum = {1'b0, ptr_q} + (MW+1)'(k);
            if (rr_sum >= (MW+1)'(NUM_MASTERS)) begin
                rr_sum = rr_sum - (MW+1)'(NUM_MASTERS);
            end
            rr_idx = rr_sum[MW-1:0];
            if (wbm_cyc_i[rr_idx]) begin
                rr_pick = rr_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;

        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        wbm_dat_o = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
`ifdef WB_ARB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        err_pulse_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (|wbm_cyc_i) begin
                    grant_d = rr_pick;
                    state_d = ST_OWN;
`ifdef WB_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end

            ST_OWN: begin
                wbs_adr_o = m_adr[grant_q];
                wbs_dat_o = m_dat[grant_q];
                wbs_sel_o = m_sel[grant_q];
                wbs_we_o  = wbm_we_i[grant_q];
                wbs_cyc_o = wbm_cyc_i[grant_q];
                // Gate stb with cyc so release drops both in the same cycle.
                wbs_stb_o = wbm_cyc_i[grant_q] & wbm_stb_i[grant_q];
                wbs_cti_o = m_cti[grant_q];
                wbs_bte_o = m_bte[grant_q];

                wbm_dat_o          = wbs_dat_i;
                wbm_ack_o[grant_q] = wbs_ack_i;
                wbm_err_o[grant_q] = wbs_err_i;
                wbm_rty_o[grant_q] = wbs_rty_i;

                if (!wbm_cyc_i[grant_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_idx(grant_q);
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (wbs_ack_i | wbs_err_i | wbs_rty_i) begin
                    tmo_cnt_d = '0;
                end else if (wbs_stb_o) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    // This strobe cycle is the TIMEOUT-th without a response.
                    if (tmo_cnt_q == TMO_LAST) begin
                        state_d     = ST_ABORT;
                        err_pulse_d = 1'b1;
                    end
                end
`endif
            end

`ifdef WB_ARB_TIMEOUT_EN
            ST_ABORT: begin
                wbm_err_o[grant_q] = err_pulse_q;
                if (!wbm_cyc_i[grant_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_idx(grant_q);
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
`ifdef WB_ARB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            err_pulse_q <= err_pulse_d;
`endif
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q != ST_IDLE);

endmodule
